adv7611_init_seq: RTL and testbench
===================================

# adv7611_init_seq

Configuration sequencer that brings the ADV7611 HDMI receiver out of reset and programs it from a register-table ROM, one single-byte I2C write per entry. It sits directly upstream of the I2C master and replaces the ad-hoc table-walk in the receiver top level. It owns the ROM address, the receiver reset pin and the I2C request handshake, and reports done/error to the top level.

## Interface
- NUM_ENTRIES, 36: table entries walked, indices 0..NUM_ENTRIES-1, max 64.
- RST_LOW_CYCLES, 500000: cycles rx_reset_n is held low (10 ms at 50 MHz).
- RST_WAIT_CYCLES, 250000: cycles waited after reset release before the first write.
- DELAY_UNIT, 50000: cycles per delay-entry count (1 ms).
- TIMEOUT_CYCLES, 1000000: per-phase I2C handshake timeout.
- clk_50  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled only in IDLE, DONE or ERROR.
- rom_addr  out  6  table ROM address.
- rom_data  in  24  {map addr[23:16], subaddr[15:8], data[7:0]}; one-cycle synchronous read latency.
- rx_reset_n  out  1  ADV7611 reset, active low.
- i2c_req  out  1  transaction request to the I2C master.
- i2c_wr  out  1  1 = write, 0 = read.
- i2c_len  out  8  transfer length in bytes; always 1.
- i2c_addr  out  7  device/map address.
- i2c_saddr  out  8  register subaddress.
- i2c_tx  out  8  write byte.
- i2c_rx  in  8  read byte from the I2C master.
- i2c_busy  in  1  I2C master busy.
- done  out  1  sticky; table completed.
- error  out  1  sticky; timeout, or readback mismatch when enabled.
- entry_idx  out  6  index of the current or last entry.
- mismatch_cnt  out  8  readback mismatches, saturating at 255.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, FETCH, ROM_WAIT, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, DONE, ERROR (plus RB_ISSUE, RB_WAIT_BUSY, RB_WAIT_DONE, RB_CHECK when readback is enabled).
- IDLE/DONE/ERROR with start=1: clear done, error, entry_idx and mismatch_cnt, then go to RST_LOW.
- start in any other state is ignored.
- RST_LOW: rx_reset_n=0 for RST_LOW_CYCLES, then go to RST_WAIT with rx_reset_n=1.
- RST_WAIT: wait RST_WAIT_CYCLES, then go to FETCH.
- FETCH drives rom_addr=entry_idx. ROM_WAIT waits one cycle. DECODE registers rom_data.
- Decode rules, by map byte rom_data[23:16]:
  - 8'hFF: delay entry; DELAY for data×DELAY_UNIT cycles; data=0 gives zero delay.
  - 8'hFE: end marker; go to DONE immediately.
  - Otherwise: write entry; i2c_addr=rom_data[22:16], i2c_saddr, i2c_tx, i2c_wr=1; go to ISSUE.
- ISSUE asserts i2c_req and moves to WAIT_BUSY.
- WAIT_BUSY holds i2c_req=1 with all fields stable until i2c_busy=1 is sampled. i2c_req then drops on the next edge and the state moves to WAIT_DONE.
- WAIT_DONE: the transaction is complete when i2c_busy=0 is sampled.
- Entry complete: if entry_idx==NUM_ENTRIES-1, go to DONE; else increment entry_idx and go to FETCH.
- Timeout: the counter restarts on entering WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT_CYCLES in either state goes to ERROR with i2c_req=0 and error=1. Sequencing stops; done stays 0.
- DONE/ERROR hold all outputs static; rx_reset_n=1.

## Timing
- Reset values: rom_addr=0, rx_reset_n=1, i2c_req=0, i2c_wr=1, i2c_len=1, i2c_addr=0, i2c_saddr=0, i2c_tx=0, done=0, error=0, entry_idx=0, mismatch_cnt=0; state IDLE.
- rst asserted mid-sequence: reset values on the next edge. An in-flight I2C transfer is abandoned; i2c_req drops immediately.
- start sampled at edge N gives rx_reset_n=0 from edge N+1 through N+RST_LOW_CYCLES inclusive.
- Write entry overhead: FETCH, ROM_WAIT, DECODE, ISSUE = 4 cycles before i2c_req rises.
- i2c_req is high for at least one cycle and until the cycle after busy is first sampled high.
- Delay entry: exactly 3 + data×DELAY_UNIT cycles from FETCH to the next FETCH.
- done rises one cycle after the final busy-low sample.

## Configuration
- INIT_READBACK_EN defined: after each write completes, RB_ISSUE performs a one-byte read of the same addr/subaddr with i2c_wr=0 and the same handshake and timeout rules.
  - RB_CHECK compares i2c_rx with the written byte.
  - Mismatch: mismatch_cnt increments (saturating) and error sets, but the sequence continues to the end and reaches DONE with error=1.
- Undefined: no readback states; mismatch_cnt is tied to 0.

## Test plan
- Reset and start with RST_LOW_CYCLES=4, RST_WAIT_CYCLES=2, NUM_ENTRIES=3: rx_reset_n is low exactly 4 cycles; first i2c_req rises 2+4 cycles after rx_reset_n rises.
- Table {98_F4_80, 98_01_06, 44_6C_00}, busy model 1 cycle after req and 10 cycles long: three writes with matching addr/saddr/tx; done=1, entry_idx=2.
- Delay entry FF_00_03 with DELAY_UNIT=5: no i2c_req for 3+15 cycles; the next entry is issued normally.
- i2c_busy never rises, TIMEOUT_CYCLES=20: i2c_req drops after 20 cycles; error=1, done=0; a new start restarts from entry 0.
- rst pulsed while in WAIT_DONE of entry 1: next cycle shows i2c_req=0, rx_reset_n=1, entry_idx=0, IDLE.
- INIT_READBACK_EN defined, model returns 8'h00 for subaddr 01: mismatch_cnt=1, error=1, done=1 after the last entry.

Source files
------------

// File: rtl/adv7611_init_seq.sv
// ADV7611 bring-up sequencer: pulses the receiver reset, then walks a register-table ROM issuing one I2C write per entry.
// Optional INIT_READBACK_EN reads each register back after writing it and counts mismatches.
module adv7611_init_seq #(
  parameter int NUM_ENTRIES     = 36,
  parameter int RST_LOW_CYCLES  = 500000,
  parameter int RST_WAIT_CYCLES = 250000,
  parameter int DELAY_UNIT      = 50000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        rx_reset_n,
  output logic        i2c_req,
  output logic        i2c_wr,
  output logic [7:0]  i2c_len,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_saddr,
  output logic [7:0]  i2c_tx,
  input  logic [7:0]  i2c_rx,
  input  logic        i2c_busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  entry_idx,
  output logic [7:0]  mismatch_cnt,
  output logic [3:0]  fsm_state
);

  // Handshake: i2c_req rises from ISSUE and holds with all fields stable until
  // i2c_busy=1 is sampled; the transfer is finished when i2c_busy=0 is then sampled.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RST_LOW   = 4'd1,
    RST_WAIT  = 4'd2,
    FETCH     = 4'd3,
    ROM_WAIT  = 4'd4,
    DECODE    = 4'd5,
    ISSUE     = 4'd6,
    WAIT_BUSY = 4'd7,
    WAIT_DONE = 4'd8,
    DELAY     = 4'd9,
    DONE      = 4'd10,
    ERROR     = 4'd11
`ifdef INIT_READBACK_EN
    ,
    RB_ISSUE     = 4'd12,
    RB_WAIT_BUSY = 4'd13,
    RB_WAIT_DONE = 4'd14,
    RB_CHECK     = 4'd15
`endif
  } state_t;

  localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DLY_UNIT      = 32'(DELAY_UNIT);
  localparam logic [5:0]  LAST_IDX      = 6'(NUM_ENTRIES - 1);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] dly_last, dly_last_n;
  logic [5:0]  rom_addr_n, entry_idx_n;
  logic        rx_reset_n_n, i2c_req_n, i2c_wr_n, done_n, error_n;
  logic [6:0]  i2c_addr_n;
  logic [7:0]  i2c_saddr_n, i2c_tx_n, mismatch_cnt_n;
  logic        entry_end;

`ifdef INIT_READBACK_EN
  logic [7:0]  rb_data, rb_data_n;
`else
  logic        unused_rx;
  assign unused_rx = ^i2c_rx;
`endif

  assign i2c_len   = 8'd1;
  assign fsm_state = state;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dly_last     <= '0;
      rom_addr     <= '0;
      rx_reset_n   <= 1'b1;
      i2c_req      <= 1'b0;
      i2c_wr       <= 1'b1;
      i2c_addr     <= '0;
      i2c_saddr    <= '0;
      i2c_tx       <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      entry_idx    <= '0;
      mismatch_cnt <= '0;
`ifdef INIT_READBACK_EN
      rb_data      <= '0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      dly_last     <= dly_last_n;
      rom_addr     <= rom_addr_n;
      rx_reset_n   <= rx_reset_n_n;
      i2c_req      <= i2c_req_n;
      i2c_wr       <= i2c_wr_n;
      i2c_addr     <= i2c_addr_n;
      i2c_saddr    <= i2c_saddr_n;
      i2c_tx       <= i2c_tx_n;
      done         <= done_n;
      error        <= error_n;
      entry_idx    <= entry_idx_n;
      mismatch_cnt <= mismatch_cnt_n;
`ifdef INIT_READBACK_EN
      rb_data      <= rb_data_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    dly_last_n     = dly_last;
    rom_addr_n     = rom_addr;
    rx_reset_n_n   = rx_reset_n;
    i2c_req_n      = i2c_req;
    i2c_wr_n       = i2c_wr;
    i2c_addr_n     = i2c_addr;
    i2c_saddr_n    = i2c_saddr;
    i2c_tx_n       = i2c_tx;
    done_n         = done;
    error_n        = error;
    entry_idx_n    = entry_idx;
    mismatch_cnt_n = mismatch_cnt;
    entry_end      = 1'b0;
`ifdef INIT_READBACK_EN
    rb_data_n      = rb_data;
`endif

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          done_n         = 1'b0;
          error_n        = 1'b0;
          entry_idx_n    = '0;
          mismatch_cnt_n = '0;
          rx_reset_n_n   = 1'b0;
          state_n        = RST_LOW;
        end
      end
      RST_LOW: begin
        if (cnt == RST_LOW_LAST) begin
          rx_reset_n_n = 1'b1;
          state_n      = RST_WAIT;
        end
      end
      RST_WAIT: begin
        if (cnt == RST_WAIT_LAST) state_n = FETCH;
      end
      FETCH: begin
        rom_addr_n = entry_idx;
        state_n    = ROM_WAIT;
      end
      ROM_WAIT: state_n = DECODE;
      DECODE: begin
        if (rom_data[23:16] == 8'hFE) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else if (rom_data[23:16] == 8'hFF) begin
          // A zero-length delay skips DELAY so the entry costs only its 3 fetch cycles.
          if (rom_data[7:0] == 8'd0) begin
            entry_end = 1'b1;
          end else begin
            dly_last_n = 32'(rom_data[7:0]) * DLY_UNIT - 32'd1;
            state_n    = DELAY;
          end
        end else begin
          i2c_addr_n  = rom_data[22:16];
          i2c_saddr_n = rom_data[15:8];
          i2c_tx_n    = rom_data[7:0];
          i2c_wr_n    = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        i2c_req_n = 1'b1;
        state_n   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i2c_busy) begin
          i2c_req_n = 1'b0;
          state_n   = WAIT_DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          i2c_req_n = 1'b0;
          error_n   = 1'b1;
          state_n   = ERROR;
        end
      end
      WAIT_DONE: begin
        if (!i2c_busy) begin
`ifdef INIT_READBACK_EN
          state_n = RB_ISSUE;
`else
          entry_end = 1'b1;
`endif
        end else if (cnt == TIMEOUT_LAST) begin
          error_n = 1'b1;
          state_n = ERROR;
        end
      end
      DELAY: begin
        if (cnt == dly_last) entry_end = 1'b1;
      end
`ifdef INIT_READBACK_EN
      RB_ISSUE: begin
        i2c_wr_n  = 1'b0;
        i2c_req_n = 1'b1;
        state_n   = RB_WAIT_BUSY;
      end
      RB_WAIT_BUSY: begin
        if (i2c_busy) begin
          i2c_req_n = 1'b0;
          state_n   = RB_WAIT_DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          i2c_req_n = 1'b0;
          error_n   = 1'b1;
          state_n   = ERROR;
        end
      end
      RB_WAIT_DONE: begin
        if (!i2c_busy) begin
          rb_data_n = i2c_rx;
          state_n   = RB_CHECK;
        end else if (cnt == TIMEOUT_LAST) begin
          error_n = 1'b1;
          state_n = ERROR;
        end
      end
      RB_CHECK: begin
        // A mismatch is recorded but does not stop the table walk.
        i2c_wr_n  = 1'b1;
        entry_end = 1'b1;
        if (rb_data != i2c_tx) begin
          error_n = 1'b1;
          if (mismatch_cnt != 8'hFF) mismatch_cnt_n = mismatch_cnt + 8'd1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (entry_end) begin
      if (entry_idx == LAST_IDX) begin
        done_n  = 1'b1;
        state_n = DONE;
      end else begin
        entry_idx_n = entry_idx + 6'd1;
        state_n     = FETCH;
      end
    end

    // The phase counter restarts on every state change and rests at zero when idle.
    if (state_n != state || state inside {IDLE, DONE, ERROR}) cnt_n = '0;
    else cnt_n = cnt + 32'd1;
  end

endmodule

// File: tb/tb_adv7611_init_seq.sv
// Directed bench for adv7611_init_seq: table-driven end-state vectors plus hand-written timing,
// timeout, mid-sequence reset and (with INIT_READBACK_EN) readback-mismatch sequences.
`timescale 1ns/1ps
module tb_adv7611_init_seq;

  localparam int W = 24;
`ifdef INIT_READBACK_EN
  localparam int RB_MUL   = 2;
  localparam int DONE_LAG = 2;
`else
  localparam int RB_MUL   = 1;
  localparam int DONE_LAG = 1;
`endif

  logic        clk_50 = 1'b0;
  logic        rst, start;
  logic [5:0]  rom_addr;
  logic [23:0] rom_data;
  logic        rx_reset_n, i2c_req, i2c_wr;
  logic [7:0]  i2c_len;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_saddr, i2c_tx, i2c_rx;
  logic        i2c_busy;
  logic        done, error;
  logic [5:0]  entry_idx;
  logic [7:0]  mismatch_cnt;
  logic [3:0]  fsm_state;

  always #10 clk_50 = ~clk_50;

  adv7611_init_seq #(
    .NUM_ENTRIES(3), .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(2),
    .DELAY_UNIT(5), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .rx_reset_n(rx_reset_n), .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_len(i2c_len),
    .i2c_addr(i2c_addr), .i2c_saddr(i2c_saddr), .i2c_tx(i2c_tx), .i2c_rx(i2c_rx),
    .i2c_busy(i2c_busy), .done(done), .error(error), .entry_idx(entry_idx),
    .mismatch_cnt(mismatch_cnt), .fsm_state(fsm_state)
  );

  // Synchronous table ROM, one cycle of read latency.
  logic [23:0] rom_mem [64];
  always @(posedge clk_50) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  bit model_en = 1'b0;
  bit corrupt = 1'b0;
  int txn_cnt = 0;
  int busy_fall_cyc = 0;

  typedef struct {
    logic [23:0] e0, e1, e2;
    bit          busy_on;
    logic        exp_done;
    logic        exp_error;
    logic [5:0]  exp_idx;
    int          exp_txn;
  } vec_t;
  vec_t vecs[5];

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Loads the table and queues the transactions the walk must produce.
  task automatic setup(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                       input bit busy_on);
    logic [23:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < 64; i++) rom_mem[i] = 24'hFE0000;
    for (int i = 0; i < 3; i++) rom_mem[i] = e[i];
    model_en = busy_on;
    txn_cnt  = 0;
    exp_q.delete();
    if (busy_on) begin
      for (int i = 0; i < 3; i++) begin
        if (e[i][23:16] == 8'hFE) break;
        if (e[i][23:16] != 8'hFF) begin
          exp_q.push_back({1'b1, e[i][22:16], e[i][15:8], e[i][7:0]});
`ifdef INIT_READBACK_EN
          exp_q.push_back({1'b0, e[i][22:16], e[i][15:8], e[i][7:0]});
`endif
        end
      end
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input bit done_only);
    int n;
    n = 0;
    while (!(done || (error && !done_only)) && n < 1000) begin
      tick;
      n++;
    end
    if (!(done || (error && !done_only))) bound_fail(name);
  endtask

  // I2C master model: busy rises one cycle after req is seen and stays high 10 cycles.
  initial begin
    i2c_busy = 1'b0;
    i2c_rx   = 8'h00;
    forever begin
      tick;
      if (model_en && i2c_req) begin
        txn_cnt++;
        check("txn_len", 32'(i2c_len), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL txn_unexpected: got %0h expected none", {i2c_wr, i2c_addr, i2c_saddr, i2c_tx});
        end else begin
          check("txn_fields", 32'({i2c_wr, i2c_addr, i2c_saddr, i2c_tx}), 32'(exp_q.pop_front()));
        end
        tick;
        i2c_rx   = (corrupt && !i2c_wr && i2c_saddr == 8'h01) ? 8'h00 : i2c_tx;
        i2c_busy = 1'b1;
        repeat (10) tick;
        i2c_busy      = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 24'h0;
    repeat (3) tick;

    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rx_reset_n", 32'(rx_reset_n), 32'd1);
    check("rst_req", 32'(i2c_req), 32'd0);
    check("rst_wr", 32'(i2c_wr), 32'd1);
    check("rst_len", 32'(i2c_len), 32'd1);
    check("rst_addr", 32'({i2c_addr, i2c_saddr, i2c_tx}), 32'd0);
    check("rst_done_error", 32'({done, error}), 32'd0);
    check("rst_idx", 32'(entry_idx), 32'd0);
    check("rst_mcnt", 32'(mismatch_cnt), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    tick;

    // Reset pulse width, first-request latency, req width and done lag.
    setup(24'h98F480, 24'h980106, 24'h446C00, 1'b1);
    pulse_start;
    n = 0;
    while (!rx_reset_n && n < 100) begin n++; tick; end
    check("rst_low_cycles", 32'(n), 32'd4);
    n = 0;
    while (!i2c_req && n < 100) begin tick; n++; end
    check("first_req_latency", 32'(n), 32'd6);
    n = 0;
    while (i2c_req && n < 100) begin n++; tick; end
    check("req_high_cycles", 32'(n), 32'd2);
    wait_end("seq_basic_end", 1'b0);
    check("done_lag", 32'(cyc - busy_fall_cyc), 32'(DONE_LAG));
    check("basic_done_error", 32'({done, error}), 32'b10);
    check("basic_idx", 32'(entry_idx), 32'd2);
    check("basic_txn", 32'(txn_cnt), 32'(3 * RB_MUL));
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Delay entry of 3 units: 2 wait + (3 + 15) delay entry + 4 overhead until req.
    setup(24'hFF0003, 24'h980106, 24'hFE0000, 1'b1);
    pulse_start;
    n = 0;
    while (!rx_reset_n && n < 100) begin n++; tick; end
    n = 0;
    while (!i2c_req && n < 100) begin tick; n++; end
    check("delay_req_latency", 32'(n), 32'd24);
    wait_end("seq_delay_end", 1'b0);
    check("delay_done", 32'({done, error}), 32'b10);
    check("delay_idx", 32'(entry_idx), 32'd2);
    check("delay_txn", 32'(txn_cnt), 32'(RB_MUL));

    // Busy never rises: req must drop after exactly 20 cycles.
    setup(24'h98F480, 24'h980106, 24'h446C00, 1'b0);
    pulse_start;
    n = 0;
    while (!i2c_req && n < 100) begin tick; n++; end
    n = 0;
    while (i2c_req && n < 100) begin n++; tick; end
    check("timeout_req_cycles", 32'(n), 32'd20);
    check("timeout_done_error", 32'({done, error}), 32'b01);
    check("timeout_state", 32'(fsm_state), 32'd11);
    repeat (5) tick;
    check("timeout_hold_idx", 32'(entry_idx), 32'd0);
    check("timeout_hold_req", 32'(i2c_req), 32'd0);

    vecs[0] = '{24'h98F480, 24'h980106, 24'h446C00, 1'b1, 1'b1, 1'b0, 6'd2, 3};
    vecs[1] = '{24'hFE0000, 24'h980106, 24'h446C00, 1'b1, 1'b1, 1'b0, 6'd0, 0};
    vecs[2] = '{24'h980106, 24'hFF0000, 24'h446C00, 1'b1, 1'b1, 1'b0, 6'd2, 2};
    vecs[3] = '{24'h98F480, 24'h980106, 24'h446C00, 1'b0, 1'b0, 1'b1, 6'd0, 0};
    vecs[4] = '{24'h446C00, 24'h98F480, 24'hFF0002, 1'b1, 1'b1, 1'b0, 6'd2, 2};
    for (int i = 0; i < 5; i++) begin
      setup(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].busy_on);
      pulse_start;
      wait_end("vec_end", 1'b0);
      repeat (14) tick;
      check("vec_done", 32'(done), 32'(vecs[i].exp_done));
      check("vec_error", 32'(error), 32'(vecs[i].exp_error));
      check("vec_idx", 32'(entry_idx), 32'(vecs[i].exp_idx));
      check("vec_txn", 32'(txn_cnt), 32'(vecs[i].exp_txn * RB_MUL));
      check("vec_q_empty", 32'(exp_q.size()), 32'd0);
      check("vec_rx_reset_n", 32'(rx_reset_n), 32'd1);
      check("vec_mcnt", 32'(mismatch_cnt), 32'd0);
    end

    // Reset while waiting for entry 1 to complete.
    setup(24'h98F480, 24'h980106, 24'h446C00, 1'b1);
    pulse_start;
    n = 0;
    while (!(entry_idx == 6'd1 && fsm_state == 4'd8) && n < 500) begin tick; n++; end
    if (!(entry_idx == 6'd1 && fsm_state == 4'd8)) bound_fail("reset_reach_wait_done");
    rst = 1'b1;
    tick;
    check("midrst_req", 32'(i2c_req), 32'd0);
    check("midrst_rx_reset_n", 32'(rx_reset_n), 32'd1);
    check("midrst_idx", 32'(entry_idx), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    repeat (15) tick;
    check("midrst_stays_idle", 32'(fsm_state), 32'd0);
    exp_q.delete();

`ifdef INIT_READBACK_EN
    // Register 01 reads back as 00: one mismatch, walk still completes.
    corrupt = 1'b1;
    setup(24'h98F480, 24'h980106, 24'h446C00, 1'b1);
    pulse_start;
    wait_end("rb_end", 1'b1);
    check("rb_mcnt", 32'(mismatch_cnt), 32'd1);
    check("rb_done_error", 32'({done, error}), 32'b11);
    check("rb_idx", 32'(entry_idx), 32'd2);
    check("rb_txn", 32'(txn_cnt), 32'd6);
    corrupt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
